// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO register-bus initiator: op codes, register
// offsets, FSM states and the offset-legality / read-modify-write helpers.
package gpio_pkg;

  localparam logic [7:0] GPIO_DATA_OFF = 8'h00;
  localparam logic [7:0] GPIO_DIR_OFF  = 8'h04;
  localparam logic [7:0] GPIO_IN_OFF   = 8'h08;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_SET   = 2'd2,
    OP_CLR   = 2'd3
  } gpio_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RSP
  } gpio_state_e;

  // IN is read-only, so only READ may target it.
  function automatic logic gpio_off_legal(gpio_op_e op, logic [31:0] addr);
    logic rw_ok;
    rw_ok = (addr == 32'(GPIO_DATA_OFF)) || (addr == 32'(GPIO_DIR_OFF));
    if (op == OP_READ) begin
      return rw_ok || (addr == 32'(GPIO_IN_OFF));
    end
    return rw_ok;
  endfunction

  function automatic logic [31:0] gpio_rmw(gpio_op_e op, logic [31:0] rdata,
                                           logic [31:0] mask);
    case (op)
      OP_SET:  return rdata | mask;
      OP_CLR:  return rdata & ~mask;
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/gpio_bus_master.sv
// Single-outstanding command initiator for the GPIO register bus with
// plain read/write plus read-modify-write bit set / bit clear.
module gpio_bus_master
  import gpio_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              bus_en,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  gpio_state_e       state_q;
  gpio_op_e          op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              bus_en_q;
  logic              bus_wr_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;

  gpio_op_e          cmd_op_e;
  logic              cmd_legal;
  logic [DATA_W-1:0] rmw_val;

  always_comb begin
    cmd_op_e  = gpio_op_e'(cmd_op);
    cmd_legal = gpio_off_legal(cmd_op_e, 32'(cmd_addr));
    rmw_val   = DATA_W'(gpio_rmw(op_q, 32'(bus_rdata), 32'(data_q)));
  end

  // Outputs are registered alongside the state so each one reflects the state
  // being entered; bus signals default to zero so a strobe lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      data_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      bus_en_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      bus_en_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op_e;
            addr_q      <= cmd_addr;
            data_q      <= cmd_data;
            cmd_ready_q <= 1'b0;
            if (!cmd_legal) begin
              state_q     <= ST_RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else if (cmd_op_e == OP_WRITE) begin
              state_q     <= ST_WR;
              bus_en_q    <= 1'b1;
              bus_wr_q    <= 1'b1;
              bus_addr_q  <= cmd_addr;
              bus_wdata_q <= cmd_data;
            end else begin
              state_q    <= ST_RD;
              bus_en_q   <= 1'b1;
              bus_addr_q <= cmd_addr;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_RD: state_q <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (op_q == OP_READ) begin
            state_q     <= ST_RSP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= bus_rdata;
          end else begin
            state_q     <= ST_WR;
            data_q      <= rmw_val;
            bus_en_q    <= 1'b1;
            bus_wr_q    <= 1'b1;
            bus_addr_q  <= addr_q;
            bus_wdata_q <= rmw_val;
          end
        end
        ST_WR: begin
          state_q     <= ST_RSP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= data_q;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign bus_en    = bus_en_q;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Self-checking bench for gpio_bus_master with a behavioural GPIO register block.
module tb_gpio_bus_master;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        bus_en;
  logic        bus_wr;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  gpio_bus_master #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .bus_en(bus_en), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // GPIO register block: registered read data, IN is a fixed read-only pattern
  localparam logic [31:0] M_IN = 32'h1234_5678;
  logic [31:0] m_data = 32'h0;
  logic [31:0] m_dir  = 32'h0;

  always @(posedge clk) begin
    if (bus_en) begin
      if (bus_wr) begin
        if (bus_addr == 8'h00) m_data <= bus_wdata;
        else if (bus_addr == 8'h04) m_dir <= bus_wdata;
      end else begin
        if (bus_addr == 8'h00) bus_rdata <= m_data;
        else if (bus_addr == 8'h04) bus_rdata <= m_dir;
        else if (bus_addr == 8'h08) bus_rdata <= M_IN;
        else bus_rdata <= 32'h0;
      end
    end
  end

  int cyc = 0;
  int n_rd = 0, n_wr = 0, idle_bad = 0;
  int last_rd_cyc = 0, last_wr_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus_en) begin
      if (bus_wr) begin n_wr = n_wr + 1; last_wr_cyc = cyc; end
      else begin n_rd = n_rd + 1; last_rd_cyc = cyc; end
    end else if (bus_addr != 8'h00 || bus_wdata != 32'h0) begin
      idle_bad = idle_bad + 1;
    end
  end

  typedef struct {
    gpio_op_e    op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_rsp(output int lat, output bit got);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = rsp_valid;
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, rsp_data, e.data);
      chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int  t_acc, rd0, wr0, lat;
    bit  got;
    wait_ready();
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_data = v.data;
    rd0 = n_rd; wr0 = n_wr; t_acc = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    sb.push_back('{v.exp_data, v.exp_err});
    wait_rsp(lat, got);
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    if (got) check_rsp(tag);
    else chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    chk({tag, "_rd_strobes"}, 32'(n_rd - rd0), 32'(v.exp_rd));
    chk({tag, "_wr_strobes"}, 32'(n_wr - wr0), 32'(v.exp_wr));
    if (v.exp_rd != 0) chk({tag, "_rd_cycle"}, 32'(last_rd_cyc - t_acc), 32'd1);
    if (v.exp_wr != 0)
      chk({tag, "_wr_cycle"}, 32'(last_wr_cyc - t_acc), (v.op == OP_WRITE) ? 32'd1 : 32'd3);
    if (got) rsp_handshake();
  endtask

  task automatic chk_outputs_zero(input string tag, input logic exp_ready);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(exp_ready));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_bus_en"}, 32'(bus_en), 32'd0);
    chk({tag, "_bus_wr"}, 32'(bus_wr), 32'd0);
    chk({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
  endtask

  vec_t vecs[12];

  initial begin
    int   lat, t_acc, strobes0, wr0;
    bit   got;
    logic [31:0] held;

    vecs[0]  = '{OP_WRITE, 8'h04, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 2, 0, 1};
    vecs[1]  = '{OP_READ,  8'h04, 32'h0,         32'hFFFF_0000, 1'b0, 3, 1, 0};
    vecs[2]  = '{OP_READ,  8'h08, 32'h0,         32'h1234_5678, 1'b0, 3, 1, 0};
    vecs[3]  = '{OP_WRITE, 8'h00, 32'h0000_000F, 32'h0000_000F, 1'b0, 2, 0, 1};
    vecs[4]  = '{OP_SET,   8'h00, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 4, 1, 1};
    vecs[5]  = '{OP_CLR,   8'h00, 32'h0000_000F, 32'h0000_00F0, 1'b0, 4, 1, 1};
    vecs[6]  = '{OP_READ,  8'h00, 32'h0,         32'h0000_00F0, 1'b0, 3, 1, 0};
    vecs[7]  = '{OP_WRITE, 8'h08, 32'hDEAD_BEEF, 32'h0,         1'b1, 1, 0, 0};
    vecs[8]  = '{OP_READ,  8'h0C, 32'h0,         32'h0,         1'b1, 1, 0, 0};
    vecs[9]  = '{OP_SET,   8'h08, 32'h0000_0001, 32'h0,         1'b1, 1, 0, 0};
    vecs[10] = '{OP_CLR,   8'h04, 32'hFF00_0000, 32'h00FF_0000, 1'b0, 4, 1, 1};
    vecs[11] = '{OP_READ,  8'h01, 32'h0,         32'h0,         1'b1, 1, 0, 0};

    @(negedge clk);
    chk_outputs_zero("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held for 10 cycles while a second command waits
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 8'h04; cmd_data = 32'hA5A5_5A5A;
    @(posedge clk);
    #1 cmd_op = OP_READ; cmd_data = 32'h0;
    sb.push_back('{32'hA5A5_5A5A, 1'b0});
    wait_rsp(lat, got);
    chk("bp_latency", 32'(lat), 32'd2);
    if (got) check_rsp("bp_first");
    held = rsp_data;
    strobes0 = n_rd + n_wr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_stable", rsp_data, held);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    chk("bp_no_strobes", 32'(n_rd + n_wr - strobes0), 32'd0);
    sb.push_back('{32'hA5A5_5A5A, 1'b0});
    rsp_handshake();
    chk("bp_accept_after_release", 32'(cmd_ready), 32'd1);
    t_acc = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp(lat, got);
    chk("bp_second_latency", 32'(lat), 32'd3);
    if (got) check_rsp("bp_second");
    chk("bp_second_rd_cycle", 32'(last_rd_cyc - t_acc), 32'd1);
    if (got) rsp_handshake();

    // Reset during RD_WAIT of a SET: no write may ever reach the register
    run_cmd('{OP_WRITE, 8'h00, 32'h0000_0003, 32'h0000_0003, 1'b0, 2, 0, 1}, "rst_pre");
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_SET; cmd_addr = 8'h00; cmd_data = 32'h0000_0030;
    wr0 = n_wr;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_rd_strobe", 32'(bus_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_outputs_zero("rst_mid", 1'b0);
    repeat (3) @(negedge clk);
    chk_outputs_zero("rst_hold", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("rst_no_write", 32'(n_wr - wr0), 32'd0);
    run_cmd('{OP_READ, 8'h00, 32'h0, 32'h0000_0003, 1'b0, 3, 1, 0}, "rst_readback");

    chk("idle_bus_zero", 32'(idle_bad), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/gpio_bus_master.md
# gpio_bus_master

Bus initiator for the GPIO register block: accepts single register commands from a processor-side valid/ready port and drives the GPIO register bus (enable, write, 8-bit offset, 32-bit write data, registered read data). Adds read-modify-write bit set and bit clear on top of plain read and write. Sits between the core's peripheral interconnect and the GPIO register block, one outstanding command at a time.

## Interface
- `ADDR_W`, 8, register offset width
- `DATA_W`, 32, register data width

- `clk`  in  1  clock, all flops on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_op`  in  2  0=WRITE, 1=READ, 2=SET (reg |= data), 3=CLR (reg &= ~data)
- `cmd_addr`  in  ADDR_W  register offset
- `cmd_data`  in  DATA_W  write value or bit mask
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`
- `rsp_data`  out  DATA_W  read value (READ) or value written (WRITE/SET/CLR); 0 on error
- `rsp_err`  out  1  illegal offset for the op
- `bus_en`  out  1  bus access strobe
- `bus_wr`  out  1  1=write, 0=read, meaningful only with `bus_en`
- `bus_addr`  out  ADDR_W  offset
- `bus_wdata`  out  DATA_W  write data
- `bus_rdata`  in  DATA_W  registered read data from GPIO block

## Operation
- Legal offsets: read 0x00 (DATA), 0x04 (DIR), 0x08 (IN); write/SET/CLR 0x00, 0x04 only. Anything else: no bus access, `rsp_err=1`, `rsp_data=0`.
- States: IDLE, RD, RD_WAIT, WR, RSP.
- IDLE: `cmd_ready=1`; on handshake latch op/addr/data; illegal → RSP; WRITE → WR; READ/SET/CLR → RD.
- RD: `bus_en=1, bus_wr=0, bus_addr=addr` → RD_WAIT.
- RD_WAIT: bus idle; capture `bus_rdata` at end of cycle. READ → RSP with captured value. SET → WR with `rdata | mask`; CLR → WR with `rdata & ~mask`.
- WR: `bus_en=1, bus_wr=1, bus_addr, bus_wdata` = value → RSP; `rsp_data` = written value.
- RSP: `rsp_valid=1`, `rsp_data`/`rsp_err` stable until `rsp_ready`; then IDLE.
- `cmd_ready=0` in every state except IDLE; commands are never dropped or reordered.
- `bus_en` is asserted exactly one cycle per access; `bus_addr`/`bus_wdata` are 0 when `bus_en=0`.
- SET/CLR are not atomic against other bus masters; GPIO block has a single initiator.

## Timing
- Reset (async assert, sync deassert handled upstream): state IDLE; `cmd_ready=0` during reset, 1 first cycle after; `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `bus_en=0`, `bus_wr=0`, `bus_addr=0`, `bus_wdata=0`.
- All outputs registered/Moore from state; no combinational path input→output except none (`cmd_ready` decoded from state only).
- Latency from accept cycle T to first `rsp_valid`: WRITE T+2, READ T+3, SET/CLR T+4, illegal T+1.
- Bus: read issued at T+1, `bus_rdata` sampled end of T+2; RMW write at T+3.
- Back-to-back: next accept no earlier than cycle after response handshake; max throughput one WRITE per 3 cycles.
- `rsp_ready` held low: stays in RSP indefinitely, no bus activity.
- Reset mid-operation: in-flight command and pending response discarded, `bus_en` drops asynchronously; partially completed RMW leaves register with read value unchanged (no write issued unless WR state was reached).

## Structure
- Shared package `gpio_pkg`: op encodings, offsets `GPIO_DATA_OFF=8'h00`, `GPIO_DIR_OFF=8'h04`, `GPIO_IN_OFF=8'h08`, state enum, legality function `gpio_off_legal(op, addr)`.
- Single module, no sub-module; RMW combine is a package function.

## Test plan
- WRITE 0x04←0xFFFF_0000: `bus_en&bus_wr` one cycle at T+1, addr 0x04; `rsp_valid` T+2, data 0xFFFF_0000, err 0.
- READ 0x08 with bus model returning 0x1234_5678 one cycle after strobe: read strobe T+1, `rsp_data=0x1234_5678` at T+3.
- SET 0x00 mask 0x0000_00F0, register holds 0x0000_000F: read at T+1, write 0x0000_00FF at T+3, rsp 0x0000_00FF at T+4; CLR mask 0x0F then yields 0x0000_00F0.
- Illegal: WRITE 0x08 and READ 0x0C → no `bus_en`, `rsp_err=1`, `rsp_data=0` at T+1.
- Backpressure: `rsp_ready=0` for 10 cycles → `rsp_valid`, data stable, `cmd_ready=0`, no bus strobes; second command accepted the cycle after release.
- Reset asserted during RD_WAIT of a SET → all outputs zero immediately, no write strobe ever issued, `cmd_ready=1` first cycle after deassert.
